branch_resolve_unit: RTL and testbench

- Resolution-side companion to the 2-bit-counter branch predictor.
- Records each predicted branch at fetch in a small in-order queue, then compares the prediction with the actual outcome from execute.
- Drives the predictor's update port (update_enable / update_pc / actual_taken) and issues the mispredict flush and redirect to fetch.

---
 rtl/branch_resolve_unit_pkg.sv | 25 ++
 rtl/bru_queue.sv | 80 ++++++++
 rtl/branch_resolve_unit.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_pkg
// Purpose  : Shared widths, queue entry layout and PC helper for the BRU.
// Revision : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

   localparam int PC_W    = 32;
   localparam int ENTRY_W = 2 * PC_W + 1;
   localparam logic [PC_W-1:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            pred_taken;
      logic [PC_W-1:0] pred_target;
   } bru_entry_t;

   // Fall-through address of a branch; wraps naturally at 32 bits.
   function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bru_queue.sv
`default_nettype none
// ============================================================================
// Module   : bru_queue
// Purpose  : In-order FIFO of predicted branches with push, pop and clear.
// Revision : 1.0 - initial release
// ============================================================================
module bru_queue
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  bru_entry_t            push_data_i,
   input  logic                  pop_i,
   input  logic                  clear_i,
   output bru_entry_t            head_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   bru_entry_t              mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   head_q, head_d;
   logic [DEPTH_LOG2-1:0]   tail_q, tail_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    w_full, w_empty, w_do_push, w_do_pop;

   assign w_full    = (count_q == C_DEPTH_CNT);
   assign w_empty   = (count_q == '0);
   // Clear has priority: a flushed cycle neither stores nor retires anything.
   assign w_do_push = push_i && !w_full && !clear_i;
   assign w_do_pop  = pop_i && !w_empty && !clear_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (w_do_push) tail_d = tail_q + DEPTH_LOG2'(1);
         if (w_do_pop)  head_d = head_q + DEPTH_LOG2'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) mem_q[tail_q] <= push_data_i;
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
   assign full_o  = w_full;
   assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Checks queued branch predictions against execute outcomes and
//            drives predictor update, mispredict flush and fetch redirect.
//            Optional statistics counters enabled by macro BRU_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_valid_i,
   input  logic [PC_W-1:0]       push_pc_i,
   input  logic                  push_pred_taken_i,
   input  logic [PC_W-1:0]       push_pred_target_i,
   output logic                  push_ready_o,
   input  logic                  resolve_valid_i,
   input  logic [PC_W-1:0]       resolve_pc_i,
   input  logic                  resolve_taken_i,
   input  logic [PC_W-1:0]       resolve_target_i,
   output logic                  update_enable_o,
   output logic [PC_W-1:0]       update_pc_o,
   output logic                  actual_taken_o,
   output logic                  mispredict_o,
   output logic [PC_W-1:0]       redirect_pc_o,
   output logic                  order_err_o,
`ifdef BRU_STATS_EN
   output logic [31:0]           stat_branches_o,
   output logic [31:0]           stat_mispredicts_o,
`endif
   output logic [DEPTH_LOG2:0]   count_o
);

   bru_entry_t              w_push_entry, w_head;
   logic [DEPTH_LOG2:0]     w_count;
   logic                    w_full, w_empty;
   logic                    w_push_acc, w_res_acc, w_res_empty;
   logic                    w_head_match, w_pred_miss, w_flush, w_update;
   logic [PC_W-1:0]         w_redirect;

   logic                    update_enable_q, update_enable_d;
   logic [PC_W-1:0]         update_pc_q, update_pc_d;
   logic                    actual_taken_q, actual_taken_d;
   logic                    mispredict_q, mispredict_d;
   logic [PC_W-1:0]         redirect_pc_q, redirect_pc_d;
   logic                    order_err_q, order_err_d;

   assign w_push_entry = '{pc: push_pc_i, pred_taken: push_pred_taken_i,
                           pred_target: push_pred_target_i};

   assign w_push_acc  = push_valid_i && !w_full;
   assign w_res_acc   = resolve_valid_i && !w_empty;
   assign w_res_empty = resolve_valid_i && w_empty;

   assign w_head_match = (w_head.pc == resolve_pc_i);
   assign w_pred_miss  = (w_head.pred_taken != resolve_taken_i) ||
                         (w_head.pred_taken && resolve_taken_i &&
                          (w_head.pred_target != resolve_target_i));
   assign w_flush      = w_res_acc && (!w_head_match || w_pred_miss);
   assign w_update     = w_res_acc && w_head_match;
   // On a head match resolve_pc equals head.pc, so one fall-through form covers both cases.
   assign w_redirect   = resolve_taken_i ? resolve_target_i : next_seq_pc(resolve_pc_i);

   bru_queue #(.DEPTH_LOG2(DEPTH_LOG2)) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_push_acc),
      .push_data_i (w_push_entry),
      .pop_i       (w_res_acc),
      .clear_i     (w_flush),
      .head_o      (w_head),
      .count_o     (w_count),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   always_comb begin
      update_enable_d = w_update;
      update_pc_d     = update_pc_q;
      actual_taken_d  = actual_taken_q;
      mispredict_d    = w_flush;
      redirect_pc_d   = redirect_pc_q;
      order_err_d     = order_err_q || w_res_empty || (w_res_acc && !w_head_match);
      if (w_update) begin
         update_pc_d    = w_head.pc;
         actual_taken_d = resolve_taken_i;
      end
      if (w_flush) redirect_pc_d = w_redirect;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         update_enable_q <= 1'b0;
         update_pc_q     <= '0;
         actual_taken_q  <= 1'b0;
         mispredict_q    <= 1'b0;
         redirect_pc_q   <= '0;
         order_err_q     <= 1'b0;
      end else begin
         update_enable_q <= update_enable_d;
         update_pc_q     <= update_pc_d;
         actual_taken_q  <= actual_taken_d;
         mispredict_q    <= mispredict_d;
         redirect_pc_q   <= redirect_pc_d;
         order_err_q     <= order_err_d;
      end
   end

`ifdef BRU_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (w_res_acc && (stat_branches_q != 32'hFFFF_FFFF))
         stat_branches_d = stat_branches_q + 32'd1;
      if (mispredict_q && (stat_mispredicts_q != 32'hFFFF_FFFF))
         stat_mispredicts_d = stat_mispredicts_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_branches_o    = stat_branches_q;
   assign stat_mispredicts_o = stat_mispredicts_q;
`endif

   assign push_ready_o    = !w_full;
   assign update_enable_o = update_enable_q;
   assign update_pc_o     = update_pc_q;
   assign actual_taken_o  = actual_taken_q;
   assign mispredict_o    = mispredict_q;
   assign redirect_pc_o   = redirect_pc_q;
   assign order_err_o     = order_err_q;
   assign count_o         = w_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push_valid = 1'b0;
   logic [31:0] push_pc = '0;
   logic        push_pred_taken = 1'b0;
   logic [31:0] push_pred_target = '0;
   logic        push_ready;
   logic        resolve_valid = 1'b0;
   logic [31:0] resolve_pc = '0;
   logic        resolve_taken = 1'b0;
   logic [31:0] resolve_target = '0;
   logic        update_enable;
   logic [31:0] update_pc;
   logic        actual_taken;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        order_err;
   logic [2:0]  count;
`ifdef BRU_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   branch_resolve_unit #(.DEPTH_LOG2(2)) dut (
      .clk                (clk),
      .rst                (rst),
      .push_valid_i       (push_valid),
      .push_pc_i          (push_pc),
      .push_pred_taken_i  (push_pred_taken),
      .push_pred_target_i (push_pred_target),
      .push_ready_o       (push_ready),
      .resolve_valid_i    (resolve_valid),
      .resolve_pc_i       (resolve_pc),
      .resolve_taken_i    (resolve_taken),
      .resolve_target_i   (resolve_target),
      .update_enable_o    (update_enable),
      .update_pc_o        (update_pc),
      .actual_taken_o     (actual_taken),
      .mispredict_o       (mispredict),
      .redirect_pc_o      (redirect_pc),
      .order_err_o        (order_err),
`ifdef BRU_STATS_EN
      .stat_branches_o    (stat_branches),
      .stat_mispredicts_o (stat_mispredicts),
`endif
      .count_o            (count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
      push_valid = 1'b1; push_pc = pc; push_pred_taken = pt; push_pred_target = tg;
   endtask

   task automatic set_resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      resolve_valid = 1'b1; resolve_pc = pc; resolve_taken = tk; resolve_target = tg;
   endtask

   task automatic release_inputs();
      push_valid = 1'b0;
      resolve_valid = 1'b0;
   endtask

   task automatic do_push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
      set_push(pc, pt, tg); tick(); release_inputs();
   endtask

   task automatic do_resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      set_resolve(pc, tk, tg); tick(); release_inputs();
   endtask

   task automatic apply_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", push_ready); end
      n_checks++; if ({update_enable, mispredict, order_err, actual_taken} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000", {update_enable, mispredict, order_err, actual_taken}); end
      n_checks++; if ({update_pc, redirect_pc} !== 64'd0) begin
         n_fail++; $display("FAIL reset_pcs: got %h %h want 0 0", update_pc, redirect_pc); end
   endtask

   task automatic test_correct_predict();
      do_push(32'h100, 1'b1, 32'h200);
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL cp_count_push: got %0d want 1", count); end
      do_resolve(32'h100, 1'b1, 32'h200);
      n_checks++; if ({update_enable, actual_taken, mispredict} !== 3'b110) begin
         n_fail++; $display("FAIL cp_flags: got %b want 110", {update_enable, actual_taken, mispredict}); end
      n_checks++; if (update_pc !== 32'h100) begin n_fail++; $display("FAIL cp_update_pc: got %h want 100", update_pc); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL cp_count: got %0d want 0", count); end
      tick();
      n_checks++; if (update_enable !== 1'b0) begin n_fail++; $display("FAIL cp_pulse_width: got %b want 0", update_enable); end
   endtask

   task automatic test_mispredict_flush();
      do_push(32'h104, 1'b0, 32'h0);
      do_push(32'h108, 1'b0, 32'h0);
      do_push(32'h10C, 1'b0, 32'h0);
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mp_count_fill: got %0d want 3", count); end
      set_resolve(32'h104, 1'b1, 32'h40);
      set_push(32'h110, 1'b0, 32'h0);
      tick(); release_inputs();
      n_checks++; if ({mispredict, update_enable, actual_taken} !== 3'b111) begin
         n_fail++; $display("FAIL mp_flags: got %b want 111", {mispredict, update_enable, actual_taken}); end
      n_checks++; if (redirect_pc !== 32'h40) begin n_fail++; $display("FAIL mp_redirect: got %h want 40", redirect_pc); end
      n_checks++; if (update_pc !== 32'h104) begin n_fail++; $display("FAIL mp_update_pc: got %h want 104", update_pc); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mp_count_flush: got %0d want 0", count); end
      tick();
      n_checks++; if ({mispredict, count} !== 4'b0000) begin
         n_fail++; $display("FAIL mp_after: got mispredict=%b count=%0d want 0 0", mispredict, count); end
   endtask

   task automatic test_redirect();
      do_push(32'h10, 1'b1, 32'h80);
      do_resolve(32'h10, 1'b0, 32'h0);
      n_checks++; if ({mispredict, redirect_pc} !== {1'b1, 32'h14}) begin
         n_fail++; $display("FAIL rd_not_taken: got %b %h want 1 14", mispredict, redirect_pc); end
      do_push(32'h10, 1'b1, 32'h80);
      do_resolve(32'h10, 1'b1, 32'h90);
      n_checks++; if ({mispredict, redirect_pc} !== {1'b1, 32'h90}) begin
         n_fail++; $display("FAIL rd_target: got %b %h want 1 90", mispredict, redirect_pc); end
      do_push(32'hFFFF_FFFC, 1'b1, 32'h80);
      do_resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
      n_checks++; if ({mispredict, redirect_pc} !== {1'b1, 32'h0}) begin
         n_fail++; $display("FAIL rd_wrap: got %b %h want 1 0", mispredict, redirect_pc); end
      tick();
   endtask

   task automatic test_full_and_wrap();
      logic [31:0] exp_pc [3];
      for (int i = 0; i < 4; i++) do_push(32'h1000 + 32'(4 * i), 1'b0, 32'h0);
      n_checks++; if ({push_ready, count} !== {1'b0, 3'd4}) begin
         n_fail++; $display("FAIL full_state: got ready=%b count=%0d want 0 4", push_ready, count); end
      do_push(32'h2000, 1'b0, 32'h0);
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_ignore: got %0d want 4", count); end
      set_push(32'h2004, 1'b0, 32'h0);
      set_resolve(32'h1000, 1'b0, 32'h0);
      tick(); release_inputs();
      n_checks++; if ({count, mispredict} !== {3'd3, 1'b0}) begin
         n_fail++; $display("FAIL full_no_bypass: got count=%0d mp=%b want 3 0", count, mispredict); end
      set_push(32'h1010, 1'b0, 32'h0);
      set_resolve(32'h1004, 1'b0, 32'h0);
      tick(); release_inputs();
      n_checks++; if ({count, update_pc} !== {3'd3, 32'h1004}) begin
         n_fail++; $display("FAIL push_pop_count: got %0d %h want 3 1004", count, update_pc); end
      exp_pc[0] = 32'h1008; exp_pc[1] = 32'h100C; exp_pc[2] = 32'h1010;
      for (int i = 0; i < 3; i++) begin
         do_resolve(exp_pc[i], 1'b0, 32'h0);
         n_checks++; if ({update_enable, mispredict, update_pc} !== {2'b10, exp_pc[i]}) begin
            n_fail++; $display("FAIL drain_%0d: got ue=%b mp=%b pc=%h want 1 0 %h", i, update_enable, mispredict, update_pc, exp_pc[i]); end
      end
      do_push(32'h3000, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         set_push(32'h3000 + 32'(4 * (i + 1)), 1'b0, 32'h0);
         set_resolve(32'h3000 + 32'(4 * i), 1'b0, 32'h0);
         tick(); release_inputs();
         n_checks++; if ({count, mispredict, update_pc} !== {3'd1, 1'b0, 32'h3000 + 32'(4 * i)}) begin
            n_fail++; $display("FAIL wrap_%0d: got count=%0d mp=%b pc=%h", i, count, mispredict, update_pc); end
      end
      do_resolve(32'h3028, 1'b0, 32'h0);
      n_checks++; if ({count, update_pc, order_err} !== {3'd0, 32'h3028, 1'b0}) begin
         n_fail++; $display("FAIL wrap_final: got count=%0d pc=%h oe=%b want 0 3028 0", count, update_pc, order_err); end
   endtask

   task automatic test_order_err();
      set_resolve(32'h500, 1'b1, 32'h0);
      set_push(32'h100, 1'b1, 32'h200);
      tick(); release_inputs();
      n_checks++; if ({order_err, update_enable, mispredict} !== 3'b100) begin
         n_fail++; $display("FAIL oe_empty: got %b want 100", {order_err, update_enable, mispredict}); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL oe_push_enters: got %0d want 1", count); end
      tick();
      n_checks++; if (order_err !== 1'b1) begin n_fail++; $display("FAIL oe_sticky: got %b want 1", order_err); end
      do_resolve(32'h300, 1'b0, 32'h0);
      n_checks++; if ({order_err, mispredict, update_enable} !== 3'b110) begin
         n_fail++; $display("FAIL oe_mismatch_flags: got %b want 110", {order_err, mispredict, update_enable}); end
      n_checks++; if ({redirect_pc, count} !== {32'h304, 3'd0}) begin
         n_fail++; $display("FAIL oe_mismatch_redirect: got %h %0d want 304 0", redirect_pc, count); end
   endtask

   task automatic test_reset_midop();
      apply_reset();
      for (int i = 0; i < 3; i++) do_push(32'h700 + 32'(4 * i), 1'b1, 32'h900);
      set_resolve(32'h7FF, 1'b0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0; release_inputs();
      n_checks++; if ({count, push_ready} !== {3'd0, 1'b1}) begin
         n_fail++; $display("FAIL rstmid_count: got %0d ready=%b want 0 1", count, push_ready); end
      n_checks++; if ({update_enable, mispredict, order_err} !== 3'b000) begin
         n_fail++; $display("FAIL rstmid_pulses: got %b want 000", {update_enable, mispredict, order_err}); end
   endtask

`ifdef BRU_STATS_EN
   task automatic test_stats();
      n_checks++; if ({stat_branches, stat_mispredicts} !== 64'd0) begin
         n_fail++; $display("FAIL stats_reset: got %0d %0d want 0 0", stat_branches, stat_mispredicts); end
      do_push(32'h40, 1'b1, 32'h80); do_resolve(32'h40, 1'b1, 32'h80);
      do_push(32'h44, 1'b1, 32'h80); do_resolve(32'h44, 1'b0, 32'h0);
      do_push(32'h48, 1'b1, 32'h80); do_resolve(32'h48, 1'b1, 32'h80);
      do_push(32'h4C, 1'b1, 32'h80); do_resolve(32'h4C, 1'b1, 32'h88);
      do_push(32'h50, 1'b1, 32'h80); do_resolve(32'h50, 1'b1, 32'h80);
      tick();
      n_checks++; if ({stat_branches, stat_mispredicts} !== {32'd5, 32'd2}) begin
         n_fail++; $display("FAIL stats_counts: got %0d %0d want 5 2", stat_branches, stat_mispredicts); end
   endtask
`endif

   initial begin
      apply_reset();
      test_reset();
      test_correct_predict();
      test_mispredict_flush();
      test_redirect();
      test_full_and_wrap();
      test_order_err();
      test_reset_midop();
`ifdef BRU_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
